// File: rtl/mul_div_if.sv
// Handshake and operand bus between a requester and the multiply/divide unit.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface mul_div_if #(
    parameter int WORD_WIDTH = `WORD_WIDTH
);
    logic                  start;
    logic [1:0]            op;
    logic [WORD_WIDTH-1:0] src_a;
    logic [WORD_WIDTH-1:0] src_b;
    logic                  busy;
    logic                  done;
    logic [WORD_WIDTH-1:0] result;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, result
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply / restoring divide unit.
// One bit is processed per cycle. Latency is fixed at WORD_WIDTH cycles for all ops.
// The same two working registers are shared by both algorithms:
//   multiply: acc_r = running high half, lo_r = multiplier shifting out / product low half
//   divide  : acc_r = partial remainder,  lo_r = dividend shifting out / quotient shifting in
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mul_div_unit #(
    parameter int WORD_WIDTH = `WORD_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    mul_div_if.slave   io
);
    localparam int CW = $clog2(WORD_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                state_r;
    logic [1:0]            op_r;
    logic [WORD_WIDTH-1:0] opnd_r;      // multiplicand or divisor
    logic [WORD_WIDTH-1:0] acc_r;
    logic [WORD_WIDTH-1:0] lo_r;
    logic [CW-1:0]         cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic [WORD_WIDTH-1:0] result_r;

    logic [WORD_WIDTH-1:0] addend_s;
    logic [WORD_WIDTH:0]   sum_s;
    logic [WORD_WIDTH-1:0] wr_s;
    logic                  div_ok_s;
    logic [WORD_WIDTH-1:0] acc_nxt_s;
    logic [WORD_WIDTH-1:0] lo_nxt_s;

    // One iteration of shift-add multiply or restoring divide on the latched operands.
    always_comb begin
        addend_s  = '0;
        sum_s     = '0;
        wr_s      = '0;
        div_ok_s  = 1'b0;
        acc_nxt_s = acc_r;
        lo_nxt_s  = lo_r;
        if (op_r[1] == 1'b0) begin
            // Add the multiplicand when the current multiplier bit is set, then shift the
            // whole (carry, acc, lo) chain right by one.
            if (lo_r[0]) begin
                addend_s = opnd_r;
            end else begin
                addend_s = '0;
            end
            sum_s     = {1'b0, acc_r} + {1'b0, addend_s};
            acc_nxt_s = sum_s[WORD_WIDTH:1];
            lo_nxt_s  = {sum_s[0], lo_r[WORD_WIDTH-1:1]};
        end else begin
            // Shift the next dividend bit into the remainder. The bit shifted out of acc_r
            // is kept separately so the compare never needs a wider subtractor; when it is
            // set the shifted remainder is certainly >= divisor. A zero divisor always
            // "fits", which yields an all-ones quotient and returns the dividend.
            wr_s     = {acc_r[WORD_WIDTH-2:0], lo_r[WORD_WIDTH-1]};
            div_ok_s = acc_r[WORD_WIDTH-1] | (wr_s >= opnd_r);
            if (div_ok_s) begin
                acc_nxt_s = wr_s - opnd_r;
            end else begin
                acc_nxt_s = wr_s;
            end
            lo_nxt_s = {lo_r[WORD_WIDTH-2:0], div_ok_s};
        end
    end

    // Control FSM with registered busy/done/result; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            op_r     <= 2'b00;
            opnd_r   <= '0;
            acc_r    <= '0;
            lo_r     <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (io.start) begin
                        op_r   <= io.op;
                        acc_r  <= '0;
                        cnt_r  <= '0;
                        busy_r <= 1'b1;
                        state_r <= RUN;
                        if (io.op[1]) begin
                            opnd_r <= io.src_b;
                            lo_r   <= io.src_a;
                        end else begin
                            opnd_r <= io.src_a;
                            lo_r   <= io.src_b;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    acc_r <= acc_nxt_s;
                    lo_r  <= lo_nxt_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_ITER) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        // High word / remainder live in acc, low word / quotient in lo.
                        if (op_r[0]) begin
                            result_r <= acc_nxt_s;
                        end else begin
                            result_r <= lo_nxt_s;
                        end
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign io.busy   = busy_r;
    assign io.done   = done_r;
    assign io.result = result_r;

endmodule
